// File: rtl/one_bit_cpu_pkg.sv
// Shared types for the one-bit CPU run/step controller.
package one_bit_cpu_pkg;

  typedef enum logic [1:0] {
    S_STOP = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
  localparam int unsigned CNT_W_DEF           = 16;
  localparam int unsigned PC_W_DEF            = 4;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability-count debouncer and a one-cycle pulse on each
// accepted press. Releases are debounced too but never produce a pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic step_req_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;
  logic          req_q;
  logic          btn_s;

  assign btn_s      = sync_q[1];
  assign step_req_o = req_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      req_q  <= 1'b0;
      // Any cycle matching the accepted level restarts the stability window.
      if (btn_s == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= btn_s;
        cnt_q   <= '0;
        req_q   <= btn_s;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/step controller: turns clk_slow rising edges into one-cycle cpu_en pulses.
// Optional breakpoint stop in free run is enabled by defining CPU_STEP_BREAK_EN.
module cpu_step_ctrl
  import one_bit_cpu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter int unsigned PC_W            = PC_W_DEF
) (
  input  logic             clk_quick,
  input  logic             rst,
  input  logic             clk_slow,
  input  logic             sw_run,
  input  logic             btn_step,
  input  logic             cpu_halt,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  bp_addr,
  output logic             cpu_en,
  output logic             running,
  output logic [CNT_W-1:0] step_count
);

  state_e           state_q;
  logic [1:0]       sw_sync_q;
  logic             clk_slow_q;
  logic             cpu_en_q;
  logic             running_q;
  logic [CNT_W-1:0] step_count_q;
  logic             sw_run_s;
  logic             tick;
  logic             step_req;
  logic             bp_hit;
  logic             cnt_full;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk_i      (clk_quick),
    .rst_i      (rst),
    .btn_i      (btn_step),
    .step_req_o (step_req)
  );

`ifdef CPU_STEP_BREAK_EN
  assign bp_hit = (pc == bp_addr);
`else
  logic unused_bp;
  assign unused_bp = ^{pc, bp_addr};
  assign bp_hit    = 1'b0;
`endif

  assign sw_run_s   = sw_sync_q[1];
  assign tick       = clk_slow & ~clk_slow_q;
  assign cnt_full   = &step_count_q;
  assign cpu_en     = cpu_en_q;
  assign running    = running_q;
  assign step_count = step_count_q;

  // clk_slow_q resets high so a prescaler already high at release is not a tick.
  always_ff @(posedge clk_quick) begin
    if (rst) begin
      state_q      <= S_STOP;
      sw_sync_q    <= '0;
      clk_slow_q   <= 1'b1;
      cpu_en_q     <= 1'b0;
      running_q    <= 1'b0;
      step_count_q <= '0;
    end else begin
      sw_sync_q  <= {sw_sync_q[0], sw_run};
      clk_slow_q <= clk_slow;
      cpu_en_q   <= 1'b0;
      if (cpu_halt) begin
        state_q   <= S_HALT;
        running_q <= 1'b0;
      end else begin
        case (state_q)
          S_STOP: begin
            if (sw_run_s) begin
              state_q   <= S_RUN;
              running_q <= 1'b1;
            end else if (step_req) begin
              state_q <= S_STEP;
            end
          end
          S_RUN: begin
            if (!sw_run_s) begin
              state_q   <= S_STOP;
              running_q <= 1'b0;
            end else if (tick) begin
              if (bp_hit) begin
                state_q   <= S_STOP;
                running_q <= 1'b0;
              end else begin
                cpu_en_q <= 1'b1;
                if (!cnt_full) step_count_q <= step_count_q + CNT_W'(1);
              end
            end
          end
          S_STEP: begin
            if (tick) begin
              state_q  <= S_STOP;
              cpu_en_q <= 1'b1;
              if (!cnt_full) step_count_q <= step_count_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= S_HALT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: directed scenarios plus random traffic, all checked
// every cycle against a behavioural model; CPU_STEP_BREAK_EN selects breakpoint expectations.
module tb_cpu_step_ctrl;

  localparam int DEB     = 16;
  localparam int CNT_W   = 4;
  localparam int PC_W    = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk_quick = 1'b0;
  logic             rst       = 1'b1;
  logic             clk_slow  = 1'b0;
  logic             sw_run    = 1'b0;
  logic             btn_step  = 1'b0;
  logic             cpu_halt  = 1'b0;
  logic [PC_W-1:0]  pc        = '0;
  logic [PC_W-1:0]  bp_addr   = 4'hF;
  logic             cpu_en;
  logic             running;
  logic [CNT_W-1:0] step_count;

  always #5 clk_quick = ~clk_quick;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (CNT_W),
    .PC_W            (PC_W)
  ) dut (
    .clk_quick  (clk_quick),
    .rst        (rst),
    .clk_slow   (clk_slow),
    .sw_run     (sw_run),
    .btn_step   (btn_step),
    .cpu_halt   (cpu_halt),
    .pc         (pc),
    .bp_addr    (bp_addr),
    .cpu_en     (cpu_en),
    .running    (running),
    .step_count (step_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Prescaler stand-in: RATIO=4, level changes every 2 fast cycles.
  logic [1:0] slow_ph = 2'd0;
  initial begin
    forever begin
      @(posedge clk_quick);
      #1;
      slow_ph  = slow_ph + 2'd1;
      clk_slow = slow_ph[1];
    end
  end

  // Behavioural model: delay lines for the synchronizers, a run-length count
  // for the debouncer and a four-way mode for run/step/halt behaviour.
  typedef enum int {M_IDLE, M_FREE, M_ARMED, M_DEAD} mmode_e;
  mmode_e m_mode;
  bit     sw_q[$];
  bit     b_q[$];
  bit     m_lvl, m_req, m_slow_prev, m_en;
  int     m_run, m_cnt;
  int     cyc = 0;
  int     pulse_total = 0;
  int     pulse_cycle[$];

  initial begin
    bit tick, sw_s, btn_s, req, brk, new_en;
    forever begin
      @(posedge clk_quick);
      cyc++;
      if (rst) begin
        m_mode = M_IDLE; sw_q = '{1'b0, 1'b0}; b_q = '{1'b0, 1'b0};
        m_lvl = 0; m_req = 0; m_run = 0; m_slow_prev = 1; m_en = 0; m_cnt = 0;
      end else begin
        tick  = clk_slow && !m_slow_prev;
        sw_s  = sw_q[0];
        btn_s = b_q[0];
        req   = m_req;
`ifdef CPU_STEP_BREAK_EN
        brk = (pc == bp_addr);
`else
        brk = 0;
`endif
        new_en = 0;
        if (cpu_halt) m_mode = M_DEAD;
        else begin
          case (m_mode)
            M_IDLE:  if (sw_s) m_mode = M_FREE; else if (req) m_mode = M_ARMED;
            M_FREE:  if (!sw_s) m_mode = M_IDLE;
                     else if (tick) begin
                       if (brk) m_mode = M_IDLE; else new_en = 1;
                     end
            M_ARMED: if (tick) begin new_en = 1; m_mode = M_IDLE; end
            default: ;
          endcase
        end
        m_en = new_en;
        if (new_en && m_cnt < CNT_MAX) m_cnt++;
        m_req = 0;
        if (btn_s != m_lvl) begin
          m_run++;
          if (m_run == DEB) begin
            m_lvl = btn_s; m_run = 0; m_req = btn_s;
          end
        end else m_run = 0;
        void'(sw_q.pop_front()); sw_q.push_back(sw_run);
        void'(b_q.pop_front());  b_q.push_back(btn_step);
        m_slow_prev = clk_slow;
      end
      @(negedge clk_quick);
      check("cpu_en", cpu_en, m_en);
      check("running", running, int'(m_mode == M_FREE));
      check("step_count", step_count, m_cnt);
      if (cpu_en) begin
        pulse_total++;
        pulse_cycle.push_back(cyc);
      end
      if (rst) pc = '0;
      else if (cpu_en) pc = pc + 1'b1;
    end
  end

  task automatic cyc_n(input int n);
    repeat (n) begin
      @(posedge clk_quick);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    cyc_n(n);
    rst = 1'b0;
  endtask

  task automatic press(input int hold, input int after);
    btn_step = 1'b1;
    cyc_n(hold);
    btn_step = 1'b0;
    cyc_n(after);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, g, n;
    int btn_hold;

    // 1: free run, pulse spacing and count
    cyc_n(3);
    rst = 1'b0;
    sw_run = 1'b1;
    base = pulse_total;
    g = 0;
    while (pulse_total - base < 5 && g < 100) begin cyc_n(1); g++; end
    check("t1_pulses", pulse_total - base, 5);
    check("t1_step_count", step_count, 5);
    check("t1_running", running, 1);
    n = pulse_cycle.size();
    for (int i = n - 4; i < n; i++)
      if (i >= 1) check("t1_spacing", pulse_cycle[i] - pulse_cycle[i-1], 4);

    // 2: bouncy press then long hold gives exactly one step
    sw_run = 1'b0;
    do_reset(3);
    base = pulse_total;
    for (int i = 0; i < 4; i++) begin btn_step = i[0]; cyc_n(1); end
    press(30, 40);
    check("t2_pulses", pulse_total - base, 1);
    check("t2_step_count", step_count, 1);
    check("t2_running", running, 0);

    // 3: drop sw_run at each phase relative to the tick
    for (int p = 0; p < 4; p++) begin
      sw_run = 1'b0;
      do_reset(3);
      sw_run = 1'b1;
      cyc_n(12);
      g = 0;
      while (!cpu_en && g < 20) begin cyc_n(1); g++; end
      check("t3_sync_pulse", cpu_en, 1);
      base = pulse_total + 1;
      cyc_n(p);
      sw_run = 1'b0;
      cyc_n(40);
      check($sformatf("t3_late_pulses_p%0d", p), pulse_total - base, (p >= 2) ? 1 : 0);
      check("t3_running", running, 0);
    end

    // 4: halt is sticky until reset
    do_reset(3);
    sw_run = 1'b1;
    cyc_n(12);
    cpu_halt = 1'b1;
    cyc_n(1);
    cpu_halt = 1'b0;
    base = pulse_total;
    sw_run = 1'b0; cyc_n(6);
    sw_run = 1'b1; cyc_n(6);
    sw_run = 1'b0;
    press(25, 20);
    check("t4_halt_pulses", pulse_total - base, 0);
    check("t4_halt_running", running, 0);
    do_reset(2);
    check("t4_rst_running", running, 0);
    check("t4_rst_cpu_en", cpu_en, 0);
    check("t4_rst_count", step_count, 0);
    base = pulse_total;
    press(25, 20);
    check("t4_step_after_rst", pulse_total - base, 1);

    // 5: saturation
    do_reset(3);
    base = pulse_total;
    sw_run = 1'b1;
    cyc_n(84);
    check("t5_saturated", step_count, 15);
    check("t5_enough_pulses", int'(pulse_total - base >= 15), 1);
    sw_run = 1'b0;

    // 6: breakpoint at pc=5
    do_reset(3);
    bp_addr = 4'd5;
    base = pulse_total;
    cyc_n(1);
    sw_run = 1'b1;
    cyc_n(60);
`ifdef CPU_STEP_BREAK_EN
    check("t6_bp_pulses", pulse_total - base, 5);
    check("t6_bp_pc", int'(pc), 5);
    check("t6_bp_running", running, 0);
    sw_run = 1'b0;
    cyc_n(4);
    press(25, 10);
    check("t6_step_pulses", pulse_total - base, 6);
    check("t6_step_pc", int'(pc), 6);
`else
    check("t6_runs_past_bp", int'(pulse_total - base > 5), 1);
    check("t6_running", running, 1);
`endif
    sw_run = 1'b0;

    // Random traffic
    do_reset(2);
    btn_hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) sw_run = ~sw_run;
      if (btn_hold == 0) begin
        btn_step = ~btn_step;
        btn_hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(18, 40)) : int'($urandom_range(1, 6));
      end else btn_hold--;
      cpu_halt = ($urandom_range(0, 299) == 0);
      rst      = ($urandom_range(0, 119) == 0);
      if (i % 100 == 0) bp_addr = 4'($urandom_range(0, 15));
      cyc_n(1);
    end
    rst = 1'b0;
    cpu_halt = 1'b0;
    cyc_n(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
